// File: rtl/yarv_pkg.sv
// Shared encodings for the yarv RV32I multicycle core: opcodes, funct3 codes,
// ALU operations, FSM states and immediate formats.
package yarv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
    ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
  } alu_op_t;

  typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM, ST_HALT} state_t;

  typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_t;

  // alt selects SUB over ADD and SRA over SRL
  function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:  return ALU_SLL;
      F3_SLT:  return ALU_SLT;
      F3_SLTU: return ALU_SLTU;
      F3_XOR:  return ALU_XOR;
      F3_SR:   return alt ? ALU_SRA : ALU_SRL;
      F3_OR:   return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic [31:0] make_imm(input logic [31:0] ir, input imm_type_t t);
    case (t)
      IMM_S:   return {{20{ir[31]}}, ir[31:25], ir[11:7]};
      IMM_B:   return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      IMM_U:   return {ir[31:12], 12'b0};
      IMM_J:   return {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      default: return {{20{ir[31]}}, ir[31:20]};
    endcase
  endfunction

endpackage

// File: rtl/yarv_alu.sv
// Combinational RV32I ALU; also produces the three branch-compare flags of a vs b.
module yarv_alu
  import yarv_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result,
  output logic        eq,
  output logic        lt,
  output logic        ltu
);

  assign eq  = (a == b);
  assign lt  = ($signed(a) < $signed(b));
  assign ltu = (a < b);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_SLL:    result = a << b[4:0];
      ALU_SLT:    result = {31'b0, lt};
      ALU_SLTU:   result = {31'b0, ltu};
      ALU_XOR:    result = a ^ b;
      ALU_SRL:    result = a >> b[4:0];
      ALU_SRA:    result = 32'($signed(a) >>> b[4:0]);
      ALU_OR:     result = a | b;
      ALU_AND:    result = a & b;
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

endmodule

// File: rtl/yarv_core.sv
// Multicycle RV32I core (FETCH -> EXEC -> [MEM] -> FETCH) on one shared bus.
// Bus: outputs registered; a request holds addr/wdata/wstrb until a rising edge sees mem_ready=1.
module yarv_core
  import yarv_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb
);

  state_t      state;
  logic [31:0] pc;
  logic [31:0] ir;
  logic [1:0]  ea_lo;
  logic [31:0] regs [32];

  logic [6:0] opcode;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign funct7 = ir[31:25];

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? 32'd0 : regs[rs2];

  imm_type_t imm_type;
  alu_op_t   alu_op;
  logic      a_is_pc, b_is_rs2, wb_alu, is_load, is_store, is_branch, is_jal, is_jalr, legal;

  always_comb begin
    imm_type = IMM_I;
    alu_op   = ALU_ADD;
    a_is_pc  = 1'b0;
    b_is_rs2 = 1'b0;
    wb_alu   = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_branch = 1'b0;
    is_jal   = 1'b0;
    is_jalr  = 1'b0;
    legal    = 1'b0;
    case (opcode)
      OPC_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASS_B; wb_alu = 1'b1; legal = 1'b1; end
      OPC_AUIPC:  begin imm_type = IMM_U; a_is_pc = 1'b1; wb_alu = 1'b1; legal = 1'b1; end
      OPC_JAL:    begin imm_type = IMM_J; is_jal = 1'b1; legal = 1'b1; end
      OPC_JALR:   begin is_jalr = 1'b1; legal = (funct3 == 3'b000); end
      OPC_BRANCH: begin
        imm_type  = IMM_B;
        is_branch = 1'b1;
        b_is_rs2  = 1'b1;
        legal     = (funct3[2:1] != 2'b01);
      end
      OPC_LOAD:   begin is_load = 1'b1; legal = funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU}; end
      OPC_STORE:  begin imm_type = IMM_S; is_store = 1'b1; legal = funct3 inside {F3_SB, F3_SH, F3_SW}; end
      OPC_IMM: begin
        wb_alu = 1'b1;
        alu_op = alu_from_f3(funct3, (funct3 == F3_SR) && funct7[5]);
        if (funct3 == F3_SLL)     legal = (funct7 == 7'b0000000);
        else if (funct3 == F3_SR) legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
        else                      legal = 1'b1;
      end
      OPC_OP: begin
        b_is_rs2 = 1'b1;
        wb_alu   = 1'b1;
        alu_op   = alu_from_f3(funct3, funct7[5]);
        legal    = (funct7 == 7'b0000000) ||
                   ((funct7 == 7'b0100000) && ((funct3 == F3_ADD) || (funct3 == F3_SR)));
      end
      OPC_FENCE:  legal = (funct3 == 3'b000);
      OPC_SYSTEM: legal = (ir == 32'h0000_0073) || (ir == 32'h0010_0073);
      default:    legal = 1'b0;
    endcase
  end

  logic [31:0] imm, alu_a, alu_b, alu_res;
  logic        flag_eq, flag_lt, flag_ltu;
  assign imm   = make_imm(ir, imm_type);
  assign alu_a = a_is_pc ? pc : rs1_val;
  assign alu_b = b_is_rs2 ? rs2_val : imm;

  yarv_alu u_alu (
    .a      (alu_a),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_res),
    .eq     (flag_eq),
    .lt     (flag_lt),
    .ltu    (flag_ltu)
  );

  logic [31:0] pc4, pc_imm, next_pc;
  logic        taken, ea_misaligned, exec_halt;
  logic [3:0]  st_strb;
  logic [31:0] st_data;
  assign pc4    = pc + 32'd4;
  assign pc_imm = pc + imm;

  always_comb begin
    case (funct3)
      F3_BEQ:  taken = flag_eq;
      F3_BNE:  taken = !flag_eq;
      F3_BLT:  taken = flag_lt;
      F3_BGE:  taken = !flag_lt;
      F3_BLTU: taken = flag_ltu;
      F3_BGEU: taken = !flag_ltu;
      default: taken = 1'b0;
    endcase
    if (is_jalr)                      next_pc = {alu_res[31:1], 1'b0};
    else if (is_jal || (is_branch && taken)) next_pc = pc_imm;
    else                              next_pc = pc4;
    case (funct3[1:0])
      2'b00:   begin ea_misaligned = 1'b0;                 st_strb = 4'b0001 << alu_res[1:0]; st_data = {4{rs2_val[7:0]}}; end
      2'b01:   begin ea_misaligned = alu_res[0];           st_strb = 4'b0011 << alu_res[1:0]; st_data = {2{rs2_val[15:0]}}; end
      default: begin ea_misaligned = (alu_res[1:0] != 2'b00); st_strb = 4'b1111;               st_data = rs2_val; end
    endcase
    exec_halt = !legal || (next_pc[1:0] != 2'b00) || ((is_load || is_store) && ea_misaligned);
  end

  // Load lane extraction uses the byte offset captured when the MEM request was issued
  logic [31:0] lane, load_data;
  assign lane = mem_rdata >> {ea_lo, 3'b000};
  always_comb begin
    case (funct3)
      F3_LB:   load_data = {{24{lane[7]}}, lane[7:0]};
      F3_LH:   load_data = {{16{lane[15]}}, lane[15:0]};
      F3_LBU:  load_data = {24'b0, lane[7:0]};
      F3_LHU:  load_data = {16'b0, lane[15:0]};
      default: load_data = mem_rdata;
    endcase
  end

  logic        wb_en;
  logic [31:0] wb_data;
  assign wb_en = !rst &&
                 (((state == ST_EXEC) && !exec_halt && (wb_alu || is_jal || is_jalr)) ||
                  ((state == ST_MEM) && mem_ready && is_load));
  assign wb_data = (state == ST_MEM) ? load_data : ((is_jal || is_jalr) ? pc4 : alu_res);

  always_ff @(posedge clk) begin
    if (wb_en && (rd != 5'd0)) regs[rd] <= wb_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_FETCH;
      pc        <= RESET_PC;
      ir        <= '0;
      ea_lo     <= '0;
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      case (state)
        ST_FETCH: begin
          if (!mem_valid) begin
            mem_valid <= 1'b1;
            mem_addr  <= {pc[31:2], 2'b00};
            mem_wstrb <= 4'b0000;
          end else if (mem_ready) begin
            ir        <= mem_rdata;
            mem_valid <= 1'b0;
            state     <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_halt) begin
            state <= ST_HALT;
          end else if (is_load || is_store) begin
            mem_valid <= 1'b1;
            mem_addr  <= {alu_res[31:2], 2'b00};
            mem_wstrb <= is_store ? st_strb : 4'b0000;
            mem_wdata <= st_data;
            ea_lo     <= alu_res[1:0];
            state     <= ST_MEM;
          end else begin
            pc    <= next_pc;
            state <= ST_FETCH;
          end
        end
        ST_MEM: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            mem_wstrb <= 4'b0000;
            pc        <= pc4;
            state     <= ST_FETCH;
          end
        end
        default: mem_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_yarv_core.sv
// Directed bench for yarv_core: bus-slave model with ROM/RAM, a fixed program,
// per-transaction address/strobe/data checks and a final register-file scoreboard.
module tb_yarv_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_rdata, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic [31:0] rom [64];
  logic [31:0] ram [16];
  logic [31:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  yarv_core #(.RESET_PC(32'h0000_0000)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bus_read(input logic [31:0] a);
    if (a[31:24] == 8'h00) return rom[a[7:2]];
    if (a[31:24] == 8'h01) return ram[a[5:2]];
    return 32'h0;
  endfunction

  task automatic bus_txn(input string tag, input logic [31:0] exp_addr, input logic [3:0] exp_wstrb,
                         input logic [31:0] exp_wdata, input bit chk_wdata);
    int n;
    logic [31:0] a, d;
    logic [3:0]  s;
    n = 0;
    @(negedge clk);
    while (!mem_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, {31'b0, mem_valid}, 32'd1);
    if (mem_valid) begin
      check({tag, "_addr"}, mem_addr, exp_addr);
      check({tag, "_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
      if (chk_wdata) check({tag, "_wdata"}, mem_wdata, exp_wdata);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      a = mem_addr;
      s = mem_wstrb;
      d = mem_wdata;
      mem_rdata = bus_read(a);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rdata = 32'hDEAD_BEEF;
      if (s != 4'b0000 && a[31:24] == 8'h01) begin
        for (int b = 0; b < 4; b++)
          if (s[b]) ram[a[5:2]][8*b +: 8] = d[8*b +: 8];
      end
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] exp_pc);
    bus_txn(tag, exp_pc, 4'b0000, 32'h0, 1'b0);
  endtask

  // mem_ready is held high throughout to show it is ignored while idle
  task automatic idle_window(input string tag, input int cycles);
    int highs;
    highs = 0;
    mem_ready = 1'b1;
    repeat (cycles) begin
      @(negedge clk);
      if (mem_valid) highs++;
    end
    mem_ready = 1'b0;
    check(tag, highs, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;
    for (int i = 0; i < 64; i++) rom[i] = 32'h0;
    for (int i = 0; i < 16; i++) ram[i] = 32'h0;
    rom[0]  = 32'h00500093; // addi x1,x0,5
    rom[1]  = 32'h00708113; // addi x2,x1,7
    rom[2]  = 32'h401101B3; // sub  x3,x2,x1
    rom[3]  = 32'h00311213; // slli x4,x2,3
    rom[4]  = 32'h00108463; // beq  x1,x1,+8
    rom[6]  = 32'h00109463; // bne  x1,x1,+8
    rom[7]  = 32'h010002B7; // lui  x5,0x01000
    rom[8]  = 32'h020000EF; // jal  x1,+0x20
    rom[9]  = 32'h0200006F; // jal  x0,+0x20
    rom[16] = 32'h00108067; // jalr x0,1(x1)
    rom[17] = 32'h0042A023; // sw   x4,0(x5)
    rom[18] = 32'h0AB00313; // addi x6,x0,0xAB
    rom[19] = 32'h006280A3; // sb   x6,1(x5)
    rom[20] = 32'h00629123; // sh   x6,2(x5)
    rom[21] = 32'h00428383; // lb   x7,4(x5)
    rom[22] = 32'h0042C403; // lbu  x8,4(x5)
    rom[23] = 32'h00429483; // lh   x9,4(x5)
    rom[24] = 32'h0042A503; // lw   x10,4(x5)
    rom[25] = 32'h00528583; // lb   x11,5(x5)
    rom[26] = 32'h0013A633; // slt  x12,x7,x1
    rom[27] = 32'h0013B6B3; // sltu x13,x7,x1
    rom[28] = 32'h4043D713; // srai x14,x7,4
    rom[29] = 32'h0022A783; // lw   x15,2(x5)  misaligned
    ram[1]  = 32'h0000AB80;

    repeat (3) @(negedge clk);
    check("reset_valid", {31'b0, mem_valid}, 32'd0);
    check("reset_addr", mem_addr, 32'h0);
    check("reset_wstrb", {28'b0, mem_wstrb}, 32'h0);
    check("reset_wdata", mem_wdata, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("first_valid", {31'b0, mem_valid}, 32'd1);
    check("first_addr", mem_addr, 32'h0);
    check("first_wstrb", {28'b0, mem_wstrb}, 32'h0);
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", {31'b0, mem_valid}, 32'd1);
      check("hold_addr", mem_addr, 32'h0);
    end
    mem_rdata = rom[0];
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;

    fetch("f04", 32'h04);
    fetch("f08", 32'h08);
    fetch("f0c", 32'h0C);
    fetch("f10", 32'h10);
    fetch("beq_taken", 32'h18);
    fetch("bne_fall", 32'h1C);
    fetch("f20", 32'h20);
    fetch("jal_target", 32'h40);
    fetch("jalr_target", 32'h24);
    fetch("f44", 32'h44);
    bus_txn("sw", 32'h0100_0000, 4'b1111, 32'h0000_0060, 1'b1);
    fetch("f48", 32'h48);
    fetch("f4c", 32'h4C);
    bus_txn("sb", 32'h0100_0000, 4'b0010, 32'hABAB_ABAB, 1'b1);
    fetch("f50", 32'h50);
    bus_txn("sh", 32'h0100_0000, 4'b1100, 32'h00AB_00AB, 1'b1);
    fetch("f54", 32'h54);
    bus_txn("lb", 32'h0100_0004, 4'b0000, 32'h0, 1'b0);
    fetch("f58", 32'h58);
    bus_txn("lbu", 32'h0100_0004, 4'b0000, 32'h0, 1'b0);
    fetch("f5c", 32'h5C);
    bus_txn("lh", 32'h0100_0004, 4'b0000, 32'h0, 1'b0);
    fetch("f60", 32'h60);
    bus_txn("lw", 32'h0100_0004, 4'b0000, 32'h0, 1'b0);
    fetch("f64", 32'h64);
    bus_txn("lb_lane1", 32'h0100_0004, 4'b0000, 32'h0, 1'b0);
    fetch("f68", 32'h68);
    fetch("f6c", 32'h6C);
    fetch("f70", 32'h70);
    fetch("f74", 32'h74);
    idle_window("misaligned_lw_halt", 100);

    exp_q.push_back(32'h0000_0024); // x1 link from jal
    exp_q.push_back(32'd12);
    exp_q.push_back(32'd7);
    exp_q.push_back(32'd96);
    exp_q.push_back(32'h0100_0000);
    exp_q.push_back(32'h0000_00AB);
    exp_q.push_back(32'hFFFF_FF80);
    exp_q.push_back(32'h0000_0080);
    exp_q.push_back(32'hFFFF_AB80);
    exp_q.push_back(32'h0000_AB80);
    exp_q.push_back(32'hFFFF_FFAB);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'hFFFF_FFF8);
    for (int r = 1; r <= 14; r++) begin
      logic [31:0] e;
      e = exp_q.pop_front();
      check($sformatf("x%0d", r), dut.regs[r], e);
    end

    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fetch("restart", 32'h0);
    repeat (2) @(negedge clk);
    check("mid_valid_before", {31'b0, mem_valid}, 32'd1);
    check("mid_addr_before", mem_addr, 32'h04);
    rst = 1'b1;
    @(negedge clk);
    check("abort_valid", {31'b0, mem_valid}, 32'd0);
    check("abort_addr", mem_addr, 32'h0);
    check("abort_pc", dut.pc, 32'h0);
    rst = 1'b0;

    rom[0] = 32'h0000_0000;
    fetch("zero_fetch", 32'h0);
    idle_window("zero_instr_halt", 100);

    rom[0] = 32'h00500093;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fetch("recover0", 32'h0);
    fetch("recover4", 32'h04);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
